// File: rtl/mio_bus_arbiter_pkg.sv
// rtl/mio_bus_arbiter_pkg.sv - shared encodings for the memory/IO bus arbiter
package mio_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_DSP = 1'b1;

    localparam int PRIO_RR    = 0;
    localparam int PRIO_FIXED = 1;

    // MEM_LAT is at most 15, so four bits of countdown suffice
    localparam int CNT_W = 4;

endpackage

// File: rtl/mio_rr_pick.sv
// rtl/mio_rr_pick.sv - combinational two-way winner select for the bus arbiter
module mio_rr_pick
    import mio_bus_arbiter_pkg::*;
#(
    parameter int PRIO_MODE = PRIO_RR
) (
    input  logic cpu_req,
    input  logic dsp_req,
    input  logic last_grant,
    output logic any_req,
    output logic winner
);

    // On a tie, round-robin hands the bus to whoever did not own it last
    always_comb begin
        any_req = cpu_req | dsp_req;
        winner  = PORT_CPU;
        if (cpu_req && dsp_req) begin
            winner = (PRIO_MODE == PRIO_FIXED) ? PORT_CPU : ~last_grant;
        end else if (dsp_req) begin
            winner = PORT_DSP;
        end
    end

endmodule

// File: rtl/mio_bus_arbiter.sv
// rtl/mio_bus_arbiter.sv - req/ack arbiter sharing one fixed-latency memory between CPU and display
module mio_bus_arbiter
    import mio_bus_arbiter_pkg::*;
#(
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int MEM_LAT   = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          dsp_req,
    input  logic          dsp_we,
    input  logic [AW-1:0] dsp_addr,
    input  logic [DW-1:0] dsp_wdata,
    output logic [DW-1:0] dsp_rdata,
    output logic          dsp_ack,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic          grant
);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             any_req, winner;
    logic             start, finish;

    mio_rr_pick #(.PRIO_MODE(PRIO_MODE)) u_pick (
        .cpu_req    (cpu_req),
        .dsp_req    (dsp_req),
        .last_grant (grant),
        .any_req    (any_req),
        .winner     (winner)
    );

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        start      = 1'b0;
        finish     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (any_req) begin
                    start      = 1'b1;
                    state_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                cnt_next   = CNT_W'(MEM_LAT);
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_next = cnt - 1'b1;
                // the memory presents read data in the cycle the count hits zero
                if (cnt_next == '0) begin
                    finish     = 1'b1;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rdata <= '0;
            dsp_rdata <= '0;
            cpu_ack   <= 1'b0;
            dsp_ack   <= 1'b0;
            busy      <= 1'b0;
            grant     <= PORT_DSP;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            mem_en  <= start;
            busy    <= (state_next != ST_IDLE);
            cpu_ack <= finish && (grant == PORT_CPU);
            dsp_ack <= finish && (grant == PORT_DSP);
            if (start) begin
                grant     <= winner;
                mem_we    <= (winner == PORT_DSP) ? dsp_we    : cpu_we;
                mem_addr  <= (winner == PORT_DSP) ? dsp_addr  : cpu_addr;
                mem_wdata <= (winner == PORT_DSP) ? dsp_wdata : cpu_wdata;
            end
            if (finish && !mem_we) begin
                if (grant == PORT_DSP) begin
                    dsp_rdata <= mem_rdata;
                end else begin
                    cpu_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// tb/tb_mio_bus_arbiter.sv - directed bench for mio_bus_arbiter (round-robin and fixed-priority instances)
module tb_mio_bus_arbiter;

    localparam int MEM_LAT = 2;

    logic        clk, reset;
    logic        cpu_req, cpu_we, dsp_req, dsp_we;
    logic [31:0] cpu_addr, cpu_wdata, dsp_addr, dsp_wdata;

    logic [31:0] cpu_rdata0, dsp_rdata0, mem_addr0, mem_wdata0, mem_rdata0;
    logic        cpu_ack0, dsp_ack0, mem_en0, mem_we0, busy0, grant0;
    logic [31:0] cpu_rdata1, dsp_rdata1, mem_addr1, mem_wdata1;
    logic        cpu_ack1, dsp_ack1, mem_en1, mem_we1, busy1, grant1;

    int vectors;
    int miscompares;

    logic [31:0] mem [0:1023];
    int          lat_cnt;

    mio_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .PRIO_MODE(0)) u_dut_rr (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata0), .cpu_ack(cpu_ack0),
        .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
        .dsp_rdata(dsp_rdata0), .dsp_ack(dsp_ack0),
        .mem_en(mem_en0), .mem_we(mem_we0), .mem_addr(mem_addr0), .mem_wdata(mem_wdata0),
        .mem_rdata(mem_rdata0), .busy(busy0), .grant(grant0)
    );

    mio_bus_arbiter #(.AW(32), .DW(32), .MEM_LAT(MEM_LAT), .PRIO_MODE(1)) u_dut_fixed (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata1), .cpu_ack(cpu_ack1),
        .dsp_req(dsp_req), .dsp_we(dsp_we), .dsp_addr(dsp_addr), .dsp_wdata(dsp_wdata),
        .dsp_rdata(dsp_rdata1), .dsp_ack(dsp_ack1),
        .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1), .mem_wdata(mem_wdata1),
        .mem_rdata(32'h0), .busy(busy1), .grant(grant1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory model: data is driven only in the single cycle MEM_LAT after mem_en
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 ^ (32'(i) << 2);
            mem[64] <= 32'hDEAD_BEEF;
            lat_cnt <= 0;
        end else begin
            if (mem_en0 && mem_we0) mem[mem_addr0[11:2]] <= mem_wdata0;
            if (mem_en0) lat_cnt <= MEM_LAT;
            else if (lat_cnt != 0) lat_cnt <= lat_cnt - 1;
        end
    end
    assign mem_rdata0 = (lat_cnt == 1) ? mem[mem_addr0[11:2]] : 32'hBAD0_BAD0;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic do_reset;
        reset = 1'b1;
        cpu_req = 1'b0; dsp_req = 1'b0;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        vectors++; if (busy0 !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b exp 0", busy0); end
        vectors++; if (mem_en0 !== 1'b0) begin miscompares++; $display("FAIL reset_mem_en got %b exp 0", mem_en0); end
        vectors++; if (mem_we0 !== 1'b0) begin miscompares++; $display("FAIL reset_mem_we got %b exp 0", mem_we0); end
        vectors++; if ({cpu_ack0, dsp_ack0} !== 2'b00) begin miscompares++; $display("FAIL reset_acks got %b exp 00", {cpu_ack0, dsp_ack0}); end
        vectors++; if (grant0 !== 1'b1) begin miscompares++; $display("FAIL reset_grant got %b exp 1", grant0); end
        vectors++; if (mem_addr0 !== 32'h0 || mem_wdata0 !== 32'h0) begin miscompares++; $display("FAIL reset_mem_bus got %h/%h exp 0/0", mem_addr0, mem_wdata0); end
        vectors++; if (cpu_rdata0 !== 32'h0 || dsp_rdata0 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata got %h/%h exp 0/0", cpu_rdata0, dsp_rdata0); end
    endtask

    task automatic test_cpu_read;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        for (int k = 1; k <= 6; k++) begin
            step();
            vectors++; if (mem_en0 !== (k == 1)) begin miscompares++; $display("FAIL cpu_read_mem_en k=%0d got %b exp %b", k, mem_en0, (k == 1)); end
            vectors++; if (busy0 !== (k <= 4)) begin miscompares++; $display("FAIL cpu_read_busy k=%0d got %b exp %b", k, busy0, (k <= 4)); end
            vectors++; if (cpu_ack0 !== (k == 4)) begin miscompares++; $display("FAIL cpu_read_ack k=%0d got %b exp %b", k, cpu_ack0, (k == 4)); end
            vectors++; if (dsp_ack0 !== 1'b0) begin miscompares++; $display("FAIL cpu_read_dsp_ack k=%0d got %b exp 0", k, dsp_ack0); end
            if (k == 1) begin
                vectors++; if (mem_addr0 !== 32'h100) begin miscompares++; $display("FAIL cpu_read_addr got %h exp 00000100", mem_addr0); end
            end
            if (k == 4) begin
                vectors++; if (cpu_rdata0 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL cpu_read_data got %h exp deadbeef", cpu_rdata0); end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_tie_rr;
        int ca, da;
        logic cg, dg;
        ca = -1; da = -1; cg = 1'bx; dg = 1'bx;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 32'h300;
        for (int k = 1; k <= 15; k++) begin
            step();
            if (cpu_ack0) begin ca = k; cg = grant0; cpu_req = 1'b0; end
            if (dsp_ack0) begin da = k; dg = grant0; dsp_req = 1'b0; end
        end
        vectors++; if (ca !== 4 || cg !== 1'b0) begin miscompares++; $display("FAIL tie_cpu_first got cycle %0d grant %b exp cycle 4 grant 0", ca, cg); end
        vectors++; if (da !== 9 || dg !== 1'b1) begin miscompares++; $display("FAIL tie_dsp_second got cycle %0d grant %b exp cycle 9 grant 1", da, dg); end
        vectors++; if (dsp_rdata0 !== 32'hA5A5_0300) begin miscompares++; $display("FAIL tie_dsp_data got %h exp a5a50300", dsp_rdata0); end
    endtask

    task automatic test_back_to_back;
        int n0, n1, dsp1_n, overlap;
        logic [5:0] seq0, seq1;
        n0 = 0; n1 = 0; dsp1_n = 0; overlap = 0; seq0 = '0; seq1 = '0;
        do_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 32'h300;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (cpu_ack0 && dsp_ack0) overlap++;
            if (cpu_ack0 || dsp_ack0) begin
                if (n0 < 6) seq0[n0] = grant0;
                n0++;
                if (n0 == 6) begin cpu_req = 1'b0; dsp_req = 1'b0; end
            end
            if (cpu_ack1 || dsp_ack1) begin
                if (n1 < 6) seq1[n1] = grant1;
                n1++;
            end
            if (dsp_ack1) dsp1_n++;
        end
        vectors++; if (n0 !== 6 || seq0 !== 6'b101010) begin miscompares++; $display("FAIL rr_grant_seq got n=%0d seq %b exp n=6 seq 101010", n0, seq0); end
        vectors++; if (overlap !== 0) begin miscompares++; $display("FAIL rr_ack_overlap got %0d exp 0", overlap); end
        vectors++; if (n1 !== 6 || seq1 !== 6'b000000) begin miscompares++; $display("FAIL fixed_grant_seq got n=%0d seq %b exp n=6 seq 000000", n1, seq1); end
        vectors++; if (dsp1_n !== 0) begin miscompares++; $display("FAIL fixed_dsp_starve got %0d acks exp 0", dsp1_n); end
    endtask

    task automatic test_write;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h200; cpu_wdata = 32'h1234_5678;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin
                vectors++;
                if ({mem_en0, mem_we0} !== 2'b11 || mem_addr0 !== 32'h200 || mem_wdata0 !== 32'h1234_5678) begin
                    miscompares++; $display("FAIL write_issue got en/we %b%b addr %h data %h exp 11 00000200 12345678", mem_en0, mem_we0, mem_addr0, mem_wdata0);
                end
            end
            if (k == 4) begin
                vectors++; if (cpu_ack0 !== 1'b1) begin miscompares++; $display("FAIL write_ack got %b exp 1", cpu_ack0); end
                vectors++; if (cpu_rdata0 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL write_rdata_hold got %h exp deadbeef", cpu_rdata0); end
                cpu_req = 1'b0;
            end
            if (k == 6) begin
                vectors++; if ({mem_en0, mem_we0} !== 2'b01) begin miscompares++; $display("FAIL write_we_hold got en/we %b%b exp 01", mem_en0, mem_we0); end
            end
        end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
        for (int k = 1; k <= 5; k++) begin
            step();
            if (k == 1) begin
                vectors++; if (mem_we0 !== 1'b0) begin miscompares++; $display("FAIL readback_we got %b exp 0", mem_we0); end
            end
            if (k == 4) begin
                vectors++; if (cpu_ack0 !== 1'b1 || cpu_rdata0 !== 32'h1234_5678) begin miscompares++; $display("FAIL readback got ack %b data %h exp 1 12345678", cpu_ack0, cpu_rdata0); end
                cpu_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid;
        int stray, ca;
        logic cg;
        stray = 0; ca = -1; cg = 1'bx;
        dsp_req = 1'b1; dsp_we = 1'b0; dsp_addr = 32'h300;
        step(); step();
        reset = 1'b1; dsp_req = 1'b0;
        step();
        vectors++; if (busy0 !== 1'b0 || mem_en0 !== 1'b0) begin miscompares++; $display("FAIL mid_reset_idle got busy %b en %b exp 0 0", busy0, mem_en0); end
        vectors++; if (dsp_rdata0 !== 32'h0 || grant0 !== 1'b1) begin miscompares++; $display("FAIL mid_reset_regs got rdata %h grant %b exp 0 1", dsp_rdata0, grant0); end
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (dsp_ack0) stray++;
        end
        vectors++; if (stray !== 0) begin miscompares++; $display("FAIL mid_reset_no_ack got %0d acks exp 0", stray); end
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (cpu_ack0) begin ca = k; cg = grant0; cpu_req = 1'b0; end
        end
        vectors++; if (ca !== 4 || cg !== 1'b0 || cpu_rdata0 !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL post_reset_cpu got cycle %0d grant %b data %h exp 4 0 deadbeef", ca, cg, cpu_rdata0); end
    endtask

    task automatic test_dsp_during_wait;
        int ca, da;
        logic dg;
        logic [12:0] en_mask;
        ca = -1; da = -1; dg = 1'bx; en_mask = '0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h100;
        dsp_we = 1'b0; dsp_addr = 32'h304;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (mem_en0) en_mask[k] = 1'b1;
            if (k == 6 && mem_en0) begin
                vectors++; if (mem_addr0 !== 32'h304) begin miscompares++; $display("FAIL late_dsp_addr got %h exp 00000304", mem_addr0); end
            end
            if (k == 2) dsp_req = 1'b1;
            if (cpu_ack0) begin ca = k; cpu_req = 1'b0; end
            if (dsp_ack0) begin da = k; dg = grant0; dsp_req = 1'b0; end
        end
        vectors++; if (en_mask !== 13'h042) begin miscompares++; $display("FAIL late_dsp_mem_en got %h exp 042", en_mask); end
        vectors++; if (ca !== 4 || da !== 9 || dg !== 1'b1) begin miscompares++; $display("FAIL late_dsp_acks got cpu %0d dsp %0d grant %b exp 4 9 1", ca, da, dg); end
        vectors++; if (dsp_rdata0 !== 32'hA5A5_0304) begin miscompares++; $display("FAIL late_dsp_data got %h exp a5a50304", dsp_rdata0); end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        reset = 1'b1;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dsp_req = 1'b0; dsp_we = 1'b0; dsp_addr = '0; dsp_wdata = '0;
        test_reset();
        test_cpu_read();
        test_tie_rr();
        test_back_to_back();
        test_write();
        test_reset_mid();
        test_dsp_during_wait();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
